// File: rtl/ws2812b_frame_sequencer.sv
// ws2812b_frame_sequencer: turns an LED on/off mask into GRB words for a WS2812B serializer,
// then waits for the serializer to drain and holds the line low long enough to latch the frame.
module ws2812b_frame_sequencer #(
   parameter int NUM_LEDS = 12,
   parameter int RESET_CYCLES = 12000,
   parameter logic [2:0] CHAN_EN = 3'b111
) (
   input  logic clk,
   input  logic res,
   input  logic refresh,
   input  logic [NUM_LEDS-1:0] led_mask,
   input  logic [7:0] intensity,
   output logic [23:0] word,
   output logic word_valid,
   input  logic word_ready,
   input  logic ser_busy,
   output logic frame_busy,
   output logic frame_done
);
   localparam int IW = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
   localparam int CW = $clog2(RESET_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, LOAD, SEND, DRAIN, LATCH} state_t;
   state_t state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic pending, pending_n;
   logic [NUM_LEDS-1:0] mask_q, mask_n;
   logic [7:0] level_q, level_n;
   logic [7:0] chan;
   logic last;
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         state <= IDLE;
         idx <= '0;
         cnt <= '0;
         pending <= 1'b0;
         mask_q <= '0;
         level_q <= '0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         cnt <= cnt_n;
         pending <= pending_n;
         mask_q <= mask_n;
         level_q <= level_n;
      end
   end
   // Outputs decode straight from registered state, so reset clears them without waiting for a clock.
   always_comb begin
      state_n = state;
      idx_n = idx;
      cnt_n = cnt;
      pending_n = pending | (refresh & (state != IDLE));
      mask_n = mask_q;
      level_n = level_q;
      last = idx == IW'(NUM_LEDS - 1);
      chan = mask_q[idx] ? level_q : 8'h00;
      word_valid = state == SEND;
      word = word_valid ? {CHAN_EN[2] ? chan : 8'h00, CHAN_EN[1] ? chan : 8'h00, CHAN_EN[0] ? chan : 8'h00} : 24'h0;
      frame_busy = state != IDLE;
      frame_done = (state == LATCH) && (cnt == CW'(RESET_CYCLES));
      case (state)
         IDLE: if (refresh | pending) begin
            state_n = LOAD;
            pending_n = 1'b0;
         end
         LOAD: begin
            mask_n = led_mask;
            level_n = intensity;
            idx_n = '0;
            state_n = SEND;
         end
         SEND: if (word_ready) begin
            if (last) state_n = DRAIN;
            else idx_n = idx + 1'b1;
         end
         DRAIN: if (!ser_busy) begin
            state_n = LATCH;
            cnt_n = '0;
         end
         LATCH: if (frame_done) state_n = IDLE;
            else cnt_n = cnt + 1'b1;
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_ws2812b_frame_sequencer.sv
// tb_ws2812b_frame_sequencer: table vectors, randomized backpressure/drain frames and hand-written
// corner sequences, all compared against a word-level model of the LED frame.
module tb_ws2812b_frame_sequencer;
   localparam int N = 12;
   localparam int R = 40;
   localparam int R2 = 12000;
   typedef struct packed {
      logic [N-1:0] m;
      logic [7:0] lv;
      logic [23:0] w0;
      logic [23:0] w11;
   } vec_t;
   logic clk = 0, res = 0, refresh = 0, refresh2 = 0, word_ready = 1, ser_busy = 0;
   logic [N-1:0] led_mask = '0;
   logic [7:0] intensity = '0;
   logic [23:0] word, word2;
   logic word_valid, word_valid2, frame_busy, frame_busy2, frame_done, frame_done2;
   int tests = 0, fails = 0;
   bit rand_ready = 0, rand_busy = 0;
   int cyc = 0, nx = 0, done_cnt = 0, done_cyc = 0, free_cyc = 0, last_cyc = 0;
   int done2_cnt = 0, done2_cyc = 0, last2_cyc = 0;
   int stab_bad = 0, zero_bad = 0, valid_cycles = 0;
   bit tail = 0, pv = 0, pr = 0;
   logic [23:0] pw = '0;
   logic [23:0] got[$];
   logic [23:0] got2[$];
   vec_t vt[5];
   always #5 clk = ~clk;
   ws2812b_frame_sequencer #(.NUM_LEDS(N), .RESET_CYCLES(R), .CHAN_EN(3'b111)) dut (
      .clk(clk), .res(res), .refresh(refresh), .led_mask(led_mask), .intensity(intensity),
      .word(word), .word_valid(word_valid), .word_ready(word_ready), .ser_busy(ser_busy),
      .frame_busy(frame_busy), .frame_done(frame_done));
   ws2812b_frame_sequencer #(.NUM_LEDS(N), .CHAN_EN(3'b010)) dut2 (
      .clk(clk), .res(res), .refresh(refresh2), .led_mask(led_mask), .intensity(intensity),
      .word(word2), .word_valid(word_valid2), .word_ready(word_ready), .ser_busy(ser_busy),
      .frame_busy(frame_busy2), .frame_done(frame_done2));
   always @(negedge clk) begin
      cyc++;
      if (res) begin
         nx = 0;
         tail = 0;
         pv = 0;
      end else begin
         if (pv && !pr && (!word_valid || word !== pw)) stab_bad++;
         if (!word_valid && word !== 24'h0) zero_bad++;
         if (word_valid) valid_cycles++;
         if (tail && !ser_busy && !word_valid) begin
            free_cyc = cyc;
            tail = 0;
         end
         if (word_valid && word_ready) begin
            got.push_back(word);
            last_cyc = cyc;
            nx++;
            if (nx == N) tail = 1;
         end
         if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            nx = 0;
         end
         pv = word_valid;
         pr = word_ready;
         pw = word;
         if (word_valid2 && word_ready) begin
            got2.push_back(word2);
            last2_cyc = cyc;
         end
         if (frame_done2) begin
            done2_cnt++;
            done2_cyc = cyc;
         end
      end
   end
   function automatic logic [23:0] model(input logic [N-1:0] m, input logic [7:0] lv, input int i, input logic [2:0] ce);
      logic [23:0] w = '0;
      if (m[i]) for (int c = 0; c < 3; c++) if (ce[c]) w[c*8 +: 8] = lv;
      return w;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) word_ready = $urandom_range(0, 1) == 1;
      if (rand_busy) ser_busy = $urandom_range(0, 3) != 0;
   endtask
   task automatic pulse_refresh();
      refresh = 1;
      tick();
      refresh = 0;
   endtask
   task automatic wait_xfers(input int base, input int n);
      for (int k = 0; k < 500 && got.size() - base < n; k++) tick();
   endtask
   task automatic wait_done(input int d0);
      for (int k = 0; k < 3000 && done_cnt == d0; k++) tick();
   endtask
   task automatic check_frame(input string tag, input int base, input logic [N-1:0] m, input logic [7:0] lv, input int d0);
      chk({tag, " done count"}, done_cnt - d0, 1);
      chk({tag, " transfers"}, got.size() - base, N);
      for (int i = 0; i < N; i++)
         if (base + i < got.size()) chk($sformatf("%s word%0d", tag, i), got[base+i], model(m, lv, i, 3'b111));
      chk({tag, " latch time"}, done_cyc - free_cyc, R + 1);
   endtask
   task automatic run_frame(input logic [N-1:0] m, input logic [7:0] lv, input int hold, input string tag);
      int base, d0, h;
      base = got.size();
      d0 = done_cnt;
      h = 0;
      led_mask = m;
      intensity = lv;
      pulse_refresh();
      if (hold > 0) ser_busy = 1;
      for (int k = 0; k < 3000 && done_cnt == d0; k++) begin
         if (hold > 0 && got.size() - base >= N) begin
            if (h < hold) h++;
            else ser_busy = 0;
         end
         tick();
      end
      check_frame(tag, base, m, lv, d0);
   endtask
   initial begin
      int base, d0, vc0;
      logic [N-1:0] m;
      logic [7:0] lv;
      vt[0] = '{12'h005, 8'h40, 24'h404040, 24'h000000};
      vt[1] = '{12'h800, 8'h12, 24'h000000, 24'h121212};
      vt[2] = '{12'hFFF, 8'hFF, 24'hFFFFFF, 24'hFFFFFF};
      vt[3] = '{12'h000, 8'h55, 24'h000000, 24'h000000};
      vt[4] = '{12'hA01, 8'h7E, 24'h7E7E7E, 24'h7E7E7E};
      #2 res = 1;
      #3;
      chk("reset word_valid", word_valid, 0);
      chk("reset word", word, 0);
      chk("reset frame_busy", frame_busy, 0);
      chk("reset frame_done", frame_done, 0);
      tick();
      tick();
      res = 0;
      led_mask = 12'h800;
      intensity = 8'hFF;
      refresh2 = 1;
      tick();
      refresh2 = 0;
      for (int k = 0; k < R2 + 200 && done2_cnt == 0; k++) tick();
      chk("chan_en done", done2_cnt, 1);
      chk("chan_en transfers", got2.size(), N);
      for (int i = 0; i < N; i++)
         if (i < got2.size()) chk($sformatf("chan_en word%0d", i), got2[i], model(12'h800, 8'hFF, i, 3'b010));
      chk("chan_en latch time", done2_cyc - last2_cyc, R2 + 2);
      for (int v = 0; v < 5; v++) begin
         base = got.size();
         run_frame(vt[v].m, vt[v].lv, 0, $sformatf("vec%0d", v));
         if (base + N <= got.size()) begin
            chk($sformatf("vec%0d w0", v), got[base], vt[v].w0);
            chk($sformatf("vec%0d w11", v), got[base+11], vt[v].w11);
         end
      end
      rand_ready = 1;
      rand_busy = 1;
      for (int f = 0; f < 5; f++) run_frame(N'($urandom()), 8'($urandom()), 0, $sformatf("rand%0d", f));
      rand_ready = 0;
      rand_busy = 0;
      word_ready = 1;
      ser_busy = 0;
      run_frame(12'h3C5, 8'h99, 50, "drain");
      base = got.size();
      d0 = done_cnt;
      led_mask = 12'h005;
      intensity = 8'h40;
      pulse_refresh();
      wait_xfers(base, 3);
      led_mask = 12'hFFF;
      for (int p = 0; p < 3; p++) begin
         pulse_refresh();
         tick();
      end
      wait_done(d0);
      check_frame("coal first", base, 12'h005, 8'h40, d0);
      base = got.size();
      d0 = done_cnt;
      wait_done(d0);
      check_frame("coal second", base, 12'hFFF, 8'h40, d0);
      repeat (3 * R + 20) tick();
      chk("coal extra frames", done_cnt - d0, 1);
      chk("coal extra words", got.size() - base, N);
      base = got.size();
      d0 = done_cnt;
      led_mask = 12'h0F0;
      intensity = 8'h21;
      pulse_refresh();
      for (int k = 0; k < 3000 && !frame_done; k++) tick();
      chk("exit refresh first done", frame_done, 1);
      refresh = 1;
      tick();
      refresh = 0;
      base = got.size();
      d0 = done_cnt;
      led_mask = 12'h00F;
      wait_done(d0);
      check_frame("exit refresh next", base, 12'h00F, 8'h21, d0);
      base = got.size();
      led_mask = 12'hABC;
      pulse_refresh();
      wait_xfers(base, 5);
      chk("pre-reset valid", word_valid, 1);
      #2 res = 1;
      #1;
      chk("mid reset word_valid", word_valid, 0);
      chk("mid reset word", word, 0);
      chk("mid reset frame_busy", frame_busy, 0);
      chk("mid reset frame_done", frame_done, 0);
      refresh = 1;
      tick();
      tick();
      refresh = 0;
      res = 0;
      vc0 = valid_cycles;
      d0 = done_cnt;
      repeat (R + 30) tick();
      chk("post reset idle valid", valid_cycles - vc0, 0);
      chk("post reset idle done", done_cnt - d0, 0);
      m = N'($urandom());
      lv = 8'($urandom());
      run_frame(m, lv, 0, "post reset");
      chk("handshake stability", stab_bad, 0);
      chk("idle word zero", zero_bad, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ws2812b_frame_sequencer.md
WS2812B_FRAME_SEQUENCER -- requirements
Module: ws2812b_frame_sequencer

Interface
REQ-001 Parameter NUM_LEDS, default 12: LEDs in the ring, one 24-bit word each per frame.
REQ-002 Parameter RESET_CYCLES, default 12000: clk cycles of line-low latch after the last bit (300 us at 40 MHz).
REQ-003 Parameter CHAN_EN, default 3'b111: channel enables [2]=G, [1]=R, [0]=B.
REQ-004 clk  in  1  system clock (40 MHz).
REQ-005 res  in  1  reset, asynchronous, active-high.
REQ-006 refresh  in  1  single-cycle frame request from the UI controller.
REQ-007 led_mask  in  NUM_LEDS  LED on/off, bit i = LED i.
REQ-008 intensity  in  8  brightness byte for lit LEDs.
REQ-009 word  out  24  GRB word to serializer: G[23:16], R[15:8], B[7:0].
REQ-010 word_valid  out  1  word is presented.
REQ-011 word_ready  in  1  serializer accepts word this cycle.
REQ-012 ser_busy  in  1  serializer still shifting bits.
REQ-013 frame_busy  out  1  high in every state except IDLE.
REQ-014 frame_done  out  1  one-cycle pulse at end of LATCH.

Function
REQ-015 States: IDLE, LOAD, SEND, DRAIN, LATCH; encoded registers, transitions only on rising clk.
REQ-016 IDLE: refresh=1 or pending=1 -> LOAD next cycle; pending cleared on that transition.
REQ-017 LOAD (1 cycle): led_mask and intensity captured into shadow registers, LED index cleared to 0 -> SEND.
REQ-018 Shadow registers only load in LOAD; input changes mid-frame do not affect the current frame.
REQ-019 SEND: word_valid=1; word = per-channel (shadow_mask[idx] & CHAN_EN[c]) ? shadow_intensity : 8'h00.
REQ-020 Transfer = word_valid & word_ready in same cycle; word and word_valid held stable until transfer.
REQ-021 On transfer with idx < NUM_LEDS-1: idx increments, next word valid next cycle (back-to-back allowed, no bubble required).
REQ-022 On transfer with idx = NUM_LEDS-1: word_valid deasserts next cycle -> DRAIN; idx never exceeds NUM_LEDS-1.
REQ-023 DRAIN: stays while ser_busy=1; first cycle ser_busy=0 -> LATCH, latch counter cleared.
REQ-024 LATCH: counter increments each cycle; after exactly RESET_CYCLES cycles in LATCH, frame_done=1 for one cycle and -> IDLE.
REQ-025 Counter width = clog2(RESET_CYCLES+1); no wrap possible.
REQ-026 refresh while frame_busy=1 sets pending (single bit; multiple requests coalesce to one frame).
REQ-027 refresh in the same cycle LATCH exits: pending set, next frame starts (IDLE 1 cycle -> LOAD).
REQ-028 word_valid=0 and word=24'h0 in all states except SEND.
REQ-029 Exactly NUM_LEDS transfers per frame; no frame restarts or aborts before LATCH completes.

Reset
REQ-030 res=1 asynchronously forces: state IDLE, idx 0, latch counter 0, pending 0, shadow regs 0, word 24'h0, word_valid 0, frame_busy 0, frame_done 0.
REQ-031 Reset mid-frame abandons the frame; no word_valid or frame_done until a refresh after res deasserts.
REQ-032 refresh asserted while res=1 is ignored (not stored as pending).

Verification
REQ-033 Single frame: led_mask=12'h005, intensity=8'h40, word_ready=1, ser_busy=0 -> words 0 and 2 = 24'h404040, other 10 = 24'h000000, frame_done exactly 12000 cycles after LATCH entry.
REQ-034 Backpressure: word_ready toggles 1/0 randomly -> word stable while valid & !ready, exactly 12 transfers, order idx 0..11.
REQ-035 Coalescing: 3 refresh pulses during SEND with led_mask changed to 12'hFFF -> current frame keeps old mask, exactly one following frame with all words 24'h404040 (CHAN_EN=3'b111).
REQ-036 CHAN_EN=3'b010, led_mask=12'h800, intensity=8'hFF -> word 11 = 24'h00FF00, words 0..10 = 0.
REQ-037 Drain: ser_busy held 1 for 50 cycles after last transfer -> LATCH entered on first ser_busy=0 cycle, frame_done RESET_CYCLES later.
REQ-038 Reset mid-SEND at idx=5 -> all outputs at reset values in the same cycle, idle until next refresh, then full frame from idx 0.
